// File: rtl/wave_gen_ctrl.sv
// UART command controller for the waveform generators.
// Ports: clk/reset, rx byte stream in, tx response out, fo/wave_sel/gen_rst_n to generators, busy.
module wave_gen_ctrl #(
  parameter int TIMEOUT_CYC   = 50000,
  parameter int RST_PULSE_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [8:0] fo,
  output logic [1:0] wave_sel,
  output logic       gen_rst_n,
  output logic       busy
);

  localparam int TCW = $clog2(TIMEOUT_CYC + 1);
  localparam int RCW = $clog2(RST_PULSE_CYC + 1);

  localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYC - 1);
  localparam logic [RCW-1:0] PLS_LAST = RCW'(RST_PULSE_CYC - 1);

  localparam logic [7:0] CMD_F = 8'h46;
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    GET_P1,
    GET_P2,
    EXEC,
    RESTART,
    SEND
  } state_t;

  state_t state;
  state_t state_nxt;

  logic           is_f;
  logic [7:0]     p1;
  logic [7:0]     p2;
  logic [TCW-1:0] tmo_cnt;
  logic [RCW-1:0] pls_cnt;

  logic       ld_cmd;
  logic       ld_p1;
  logic       ld_p2;
  logic       clr_tmo;
  logic       inc_tmo;
  logic       ld_tx;
  logic [7:0] tx_nxt;
  logic       commit;
  logic       start_pls;

  logic [8:0] f_val;
  logic       f_ok;
  logic       w_ok;
  logic       cmd_ok;
  logic       tmo_exp;
  logic       pls_last;

  assign f_val    = {p1[0], p2};
  assign f_ok     = (f_val != 9'd0) && (f_val <= 9'd400);
  assign w_ok     = (p1 <= 8'd3);
  assign cmd_ok   = is_f ? f_ok : w_ok;
  assign tmo_exp  = (tmo_cnt == TMO_LAST);
  assign pls_last = !gen_rst_n && (pls_cnt == PLS_LAST);

  assign tx_valid = (state == SEND);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_cmd    = 1'b0;
    ld_p1     = 1'b0;
    ld_p2     = 1'b0;
    clr_tmo   = 1'b0;
    inc_tmo   = 1'b0;
    ld_tx     = 1'b0;
    tx_nxt    = 8'h00;
    commit    = 1'b0;
    start_pls = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_valid) begin
          unique case (1'b1)
            (rx_data == CMD_F),
            (rx_data == CMD_W): begin
              state_nxt = GET_P1;
              ld_cmd    = 1'b1;
              clr_tmo   = 1'b1;
            end
            (rx_data == CMD_R): begin
              state_nxt = RESTART;
              start_pls = 1'b1;
            end
            default: begin
              state_nxt = SEND;
              ld_tx     = 1'b1;
              tx_nxt    = NAK;
            end
          endcase
        end
      end
      GET_P1: begin
        // an arriving byte beats a simultaneous timeout
        if (rx_valid) begin
          ld_p1     = 1'b1;
          clr_tmo   = 1'b1;
          state_nxt = is_f ? GET_P2 : EXEC;
        end else if (tmo_exp) begin
          state_nxt = SEND;
          ld_tx     = 1'b1;
          tx_nxt    = NAK;
        end else begin
          inc_tmo = 1'b1;
        end
      end
      GET_P2: begin
        if (rx_valid) begin
          ld_p2     = 1'b1;
          clr_tmo   = 1'b1;
          state_nxt = EXEC;
        end else if (tmo_exp) begin
          state_nxt = SEND;
          ld_tx     = 1'b1;
          tx_nxt    = NAK;
        end else begin
          inc_tmo = 1'b1;
        end
      end
      EXEC: begin
        state_nxt = SEND;
        ld_tx     = 1'b1;
        tx_nxt    = cmd_ok ? ACK : NAK;
        commit    = cmd_ok;
        start_pls = cmd_ok && !is_f;
      end
      RESTART: begin
        if (pls_last) begin
          state_nxt = SEND;
          ld_tx     = 1'b1;
          tx_nxt    = ACK;
        end
      end
      SEND: begin
        if (tx_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      is_f      <= 1'b0;
      p1        <= 8'h00;
      p2        <= 8'h00;
      tmo_cnt   <= '0;
      pls_cnt   <= '0;
      tx_data   <= 8'h00;
      fo        <= 9'd1;
      wave_sel  <= 2'd0;
      gen_rst_n <= 1'b1;
    end else begin
      if (ld_cmd) begin
        is_f <= (rx_data == CMD_F);
      end
      if (ld_p1) begin
        p1 <= rx_data;
      end
      if (ld_p2) begin
        p2 <= rx_data;
      end
      if (clr_tmo) begin
        tmo_cnt <= '0;
      end else if (inc_tmo) begin
        tmo_cnt <= tmo_cnt + TCW'(1);
      end
      if (ld_tx) begin
        tx_data <= tx_nxt;
      end
      if (commit) begin
        if (is_f) begin
          fo <= f_val;
        end else begin
          wave_sel <= p1[1:0];
        end
      end
      // pulse timer runs independently of the FSM so a 'W'
      // restart can overlap the SEND state
      if (start_pls) begin
        gen_rst_n <= 1'b0;
        pls_cnt   <= '0;
      end else if (!gen_rst_n) begin
        if (pls_last) begin
          gen_rst_n <= 1'b1;
        end else begin
          pls_cnt <= pls_cnt + RCW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wave_gen_ctrl.sv
// Directed bench for wave_gen_ctrl.
// Drives command bytes and checks responses and generator controls.
module tb_wave_gen_ctrl;

  localparam int TMO = 16;
  localparam int RPC = 2;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [8:0] fo;
  logic [1:0] wave_sel;
  logic       gen_rst_n;
  logic       busy;

  int n_cmp;
  int n_err;

  wave_gen_ctrl #(
    .TIMEOUT_CYC  (TMO),
    .RST_PULSE_CYC(RPC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .fo       (fo),
    .wave_sel (wave_sel),
    .gen_rst_n(gen_rst_n),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!tx_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_seen"}, 32'(tx_valid), 32'd1);
    chk(tag, 32'(tx_data), 32'(exp));
    @(negedge clk);
    chk({tag, "_done"}, 32'(tx_valid), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic obs(input int n, output int lows, output int txv,
                     output logic [7:0] d);
    lows = 0;
    txv  = 0;
    d    = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (!gen_rst_n) lows++;
      if (tx_valid) begin
        txv++;
        d = tx_data;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lows;
    int         txv;
    int         bad;
    logic [7:0] d;

    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_fo", 32'(fo), 32'd1);
    chk("rst_wave", 32'(wave_sel), 32'd0);
    chk("rst_gen", 32'(gen_rst_n), 32'd1);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // release and present a command on the very first edge
    reset = 1'b1;
    send_byte(8'h46);
    chk("first_acc", 32'(busy), 32'd1);
    send_byte(8'h01);
    send_byte(8'hF5);
    resp("f501", 8'h15);
    chk("f501_fo", 32'(fo), 32'd1);

    send_byte(8'h46);
    send_byte(8'h01);
    chk("f_atomic", 32'(fo), 32'd1);
    send_byte(8'h2C);
    resp("f300", 8'h06);
    chk("f300_fo", 32'(fo), 32'd300);

    send_byte(8'h46);
    send_byte(8'h00);
    send_byte(8'h00);
    resp("f0", 8'h15);
    chk("f0_fo", 32'(fo), 32'd300);

    send_byte(8'h46);
    send_byte(8'h01);
    send_byte(8'h90);
    resp("f400", 8'h06);
    chk("f400_fo", 32'(fo), 32'd400);

    send_byte(8'h46);
    send_byte(8'h01);
    send_byte(8'h91);
    resp("f401", 8'h15);
    chk("f401_fo", 32'(fo), 32'd400);

    send_byte(8'h46);
    send_byte(8'hFF);
    send_byte(8'h2C);
    resp("fhi", 8'h06);
    chk("fhi_fo", 32'(fo), 32'd300);

    send_byte(8'h57);
    chk("w_atomic", 32'(wave_sel), 32'd0);
    send_byte(8'h02);
    obs(8, lows, txv, d);
    chk("w2_wave", 32'(wave_sel), 32'd2);
    chk("w2_lows", 32'(lows), 32'(RPC));
    chk("w2_txv", 32'(txv), 32'd1);
    chk("w2_resp", 32'(d), 32'h06);

    send_byte(8'h57);
    send_byte(8'h04);
    obs(8, lows, txv, d);
    chk("w4_wave", 32'(wave_sel), 32'd2);
    chk("w4_lows", 32'(lows), 32'd0);
    chk("w4_resp", 32'(d), 32'h15);

    send_byte(8'h52);
    obs(8, lows, txv, d);
    chk("r_lows", 32'(lows), 32'(RPC));
    chk("r_txv", 32'(txv), 32'd1);
    chk("r_resp", 32'(d), 32'h06);

    send_byte(8'h41);
    resp("bad_cmd", 8'h15);

    // silence after P1: expiry on the TMO-th idle cycle in GET_P2
    send_byte(8'h46);
    send_byte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_wait_busy", 32'(busy), 32'd1);
    chk("tmo_wait_txv", 32'(tx_valid), 32'd0);
    resp("tmo", 8'h15);
    chk("tmo_fo", 32'(fo), 32'd300);

    // byte arriving in the expiry cycle is taken
    send_byte(8'h46);
    send_byte(8'h00);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h2C);
    resp("tmo_race", 8'h06);
    chk("tmo_race_fo", 32'(fo), 32'd44);

    // transmitter stalls while junk bytes arrive
    tx_ready = 1'b0;
    send_byte(8'h57);
    send_byte(8'h01);
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      rx_data  = (i % 2 == 0) ? 8'h46 : 8'h52;
      rx_valid = 1'b1;
      @(negedge clk);
      if (!tx_valid || tx_data !== 8'h06) bad++;
    end
    rx_valid = 1'b0;
    chk("stall_stable", 32'(bad), 32'd0);
    tx_ready = 1'b1;
    @(negedge clk);
    chk("stall_done", 32'(tx_valid), 32'd0);
    chk("stall_drop", 32'(busy), 32'd0);
    chk("stall_wave", 32'(wave_sel), 32'd1);
    repeat (3) @(negedge clk);

    // reset between P1 and P2
    send_byte(8'h46);
    send_byte(8'h01);
    reset = 1'b0;
    #1;
    chk("mid_fo", 32'(fo), 32'd1);
    chk("mid_wave", 32'(wave_sel), 32'd0);
    chk("mid_gen", 32'(gen_rst_n), 32'd1);
    chk("mid_txv", 32'(tx_valid), 32'd0);
    chk("mid_txd", 32'(tx_data), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_valid || busy) bad++;
    end
    chk("mid_quiet", 32'(bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_gen_ctrl.md
WAVE_GEN_CTRL -- requirements
Module: wave_gen_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 50000: maximum clk cycles allowed between bytes of one command.
REQ-002 Parameter RST_PULSE_CYC, default 2: low width of gen_rst_n on restart.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 rx_data  input  8  byte from UART receiver.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data valid this cycle.
REQ-007 tx_data  output  8  response byte to UART transmitter.
REQ-008 tx_valid  output  1  response byte pending.
REQ-009 tx_ready  input  1  transmitter accepts tx_data when tx_valid && tx_ready.
REQ-010 fo  output  9  phase step to waveform generators.
REQ-011 wave_sel  output  2  active generator: 0 square, 1 triangle, 2 sine, 3 sawtooth.
REQ-012 gen_rst_n  output  1  active-low phase restart to generators.
REQ-013 busy  output  1  high whenever state != IDLE.

Function
REQ-014 FSM states SHALL be IDLE, GET_P1, GET_P2, EXEC, RESTART, SEND.
REQ-015 IDLE + rx_valid: 0x46 'F' -> GET_P1 (2 payload bytes); 0x57 'W' -> GET_P1 (1 payload byte); 0x52 'R' -> RESTART; any other byte -> SEND with NAK.
REQ-016 'F' payload: P1 bit0 = fo[8], P1 bits 7:1 ignored; P2 = fo[7:0]; GET_P1 -> GET_P2 -> EXEC.
REQ-017 'W' payload: P1 -> EXEC directly.
REQ-018 EXEC (one cycle): valid command -> commit new value, response ACK 0x06; invalid command -> keep old value, response NAK 0x15; -> SEND.
REQ-019 'F' with {P1[0],P2} == 0 or > 9'd400 SHALL be invalid; 'W' with P1 > 3 SHALL be invalid.
REQ-020 fo and wave_sel SHALL change only in EXEC, never on partial payload (atomic update).
REQ-021 'W' commit SHALL also pulse gen_rst_n low for RST_PULSE_CYC cycles, starting the cycle after EXEC, concurrently with SEND.
REQ-022 RESTART: gen_rst_n low exactly RST_PULSE_CYC cycles, then -> SEND with ACK.
REQ-023 SEND: tx_valid high, tx_data stable until tx_valid && tx_ready; that cycle -> IDLE, tx_valid low next cycle.
REQ-024 rx_valid in EXEC, RESTART or SEND SHALL be dropped without state effect.
REQ-025 Timeout counter SHALL clear on every accepted payload byte and on entry to GET_P1; reaching TIMEOUT_CYC in GET_P1/GET_P2 -> SEND with NAK, partial payload discarded.
REQ-026 Timeout counter width SHALL be $clog2(TIMEOUT_CYC+1); no wrap before expiry.
REQ-027 rx_valid and timeout expiry in the same cycle: byte wins, counter clears.
REQ-028 Back-to-back: a command byte in the cycle after SEND completes SHALL be accepted.

Reset
REQ-029 Reset asserted: state IDLE, fo = 9'd1, wave_sel = 0, gen_rst_n = 1, tx_valid = 0, tx_data = 0, busy = 0, counters 0.
REQ-030 Reset mid-command or mid-SEND SHALL abort immediately; no ACK/NAK emitted after release.
REQ-031 First command SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-032 Bytes 0x46,0x01,0x2C, tx_ready=1 -> fo = 9'd300 after EXEC, tx_data 0x06 one handshake, busy low after.
REQ-033 Bytes 0x46,0x01,0xF5 (501) -> NAK 0x15, fo unchanged at 1.
REQ-034 Bytes 0x57,0x02 -> wave_sel = 2, gen_rst_n low 2 cycles, ACK; then 0x57,0x04 -> NAK, wave_sel stays 2.
REQ-035 0x46,0x00 then silence TIMEOUT_CYC cycles -> NAK, state IDLE, fo unchanged; byte arriving on expiry cycle -> accepted instead.
REQ-036 tx_ready held low 20 cycles during SEND, extra rx bytes injected -> tx_data stable, bytes dropped, single ACK on ready.
REQ-037 Reset pulse between P1 and P2 of 'F' -> all outputs at REQ-029 values, no tx_valid after release.
